core_mul_iter: RTL and testbench

//  Iterative ARMv4 multiply unit: MUL, MLA, UMULL, UMLAL, SMULL, SMLAL.

---
 rtl/core_mul_iter.sv | 182 ++++++++++++++++++
 tb/tb_core_mul_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/core_mul_iter.sv
// Iterative ARMv4 multiply unit (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), STEP_BITS multiplier bits per cycle.
// Optional macro CORE_MUL_EARLY_TERM_EN: leave the MUL phase as soon as the remaining multiplier is zero.

module core_mul_iter #(
    parameter int STEP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in_ready,
    input  logic        add,
    input  logic        long_mul,
    input  logic        signed_mul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c_lo,
    input  logic [31:0] c_hi,
    output logic        valid,
    output logic [31:0] q_lo,
    output logic [31:0] q_hi,
    output logic        n,
    output logic        z
);

    localparam int K     = 32 / STEP_BITS;
    localparam int CNT_W = $clog2(K);

    // Handshake: an operation is accepted on a rising edge where start && in_ready.
    // in_ready is high only in IDLE; valid pulses for the single DONE cycle, and
    // q_lo/q_hi/n/z are final from that cycle until the next FIX overwrites them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]          a_mag_q;
    logic [31:0]          b_mag_q;
    logic [63:0]          p_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 add_q;
    logic                 long_q;
    logic [31:0]          c_lo_q;
    logic [31:0]          c_hi_q;

    logic                 accept;
    logic                 mag_en;
    logic [31:0]          a_abs;
    logic [31:0]          b_abs;
    logic [STEP_BITS-1:0] digit;
    logic [31+STEP_BITS:0] part;
    logic [5:0]           shamt;
    logic [63:0]          part_sh;
    logic [31:0]          b_next;
    logic                 last_iter;
    logic                 mul_done;
    logic                 skip_mul;

    logic [63:0]          p_fix;
    logic [63:0]          acc;
    logic [63:0]          sum;
    logic [31:0]          res_lo;
    logic [31:0]          res_hi;
    logic                 res_n;
    logic                 res_z;

    assign accept = start && in_ready;
    assign mag_en = signed_mul && long_mul;

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    assign a_abs = (mag_en && a[31]) ? (~a + 32'd1) : a;
    assign b_abs = (mag_en && b[31]) ? (~b + 32'd1) : b;

    assign digit     = b_mag_q[STEP_BITS-1:0];
    assign part      = {{STEP_BITS{1'b0}}, a_mag_q} * {32'd0, digit};
    assign shamt     = 6'(cnt_q) * 6'(STEP_BITS);
    assign part_sh   = {{(32-STEP_BITS){1'b0}}, part} << shamt;
    assign b_next    = b_mag_q >> STEP_BITS;
    assign last_iter = (cnt_q == CNT_W'(K - 1));

`ifdef CORE_MUL_EARLY_TERM_EN
    assign mul_done = last_iter || (b_next == 32'd0);
    assign skip_mul = (b_abs == 32'd0);
`else
    assign mul_done = last_iter;
    assign skip_mul = 1'b0;
`endif

    // Sign fix-up, then accumulate modulo 2^64; the short form keeps only 32 bits.
    assign p_fix  = neg_q ? (~p_q + 64'd1) : p_q;
    assign acc    = long_q ? {c_hi_q, c_lo_q} : {32'd0, c_lo_q};
    assign sum    = add_q ? (p_fix + acc) : p_fix;
    assign res_lo = sum[31:0];
    assign res_hi = long_q ? sum[63:32] : 32'd0;
    assign res_n  = long_q ? sum[63] : sum[31];
    assign res_z  = long_q ? (sum == 64'd0) : (sum[31:0] == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    state_d = skip_mul ? S_FIX : S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                valid   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag_q <= 32'd0;
            b_mag_q <= 32'd0;
            p_q     <= 64'd0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            add_q   <= 1'b0;
            long_q  <= 1'b0;
            c_lo_q  <= 32'd0;
            c_hi_q  <= 32'd0;
            q_lo    <= 32'd0;
            q_hi    <= 32'd0;
            n       <= 1'b0;
            z       <= 1'b0;
        end else begin
            if (accept) begin
                a_mag_q <= a_abs;
                b_mag_q <= b_abs;
                neg_q   <= mag_en && (a[31] ^ b[31]);
                add_q   <= add;
                long_q  <= long_mul;
                c_lo_q  <= c_lo;
                c_hi_q  <= c_hi;
                p_q     <= 64'd0;
                cnt_q   <= '0;
            end
            if (state_q == S_MUL) begin
                p_q     <= p_q + part_sh;
                b_mag_q <= b_next;
                cnt_q   <= last_iter ? '0 : cnt_q + CNT_W'(1);
            end
            // Results only change here, so they hold through DONE and IDLE.
            if (state_q == S_FIX) begin
                q_lo <= res_lo;
                q_hi <= res_hi;
                n    <= res_n;
                z    <= res_z;
            end
        end
    end

endmodule

// File: tb/tb_core_mul_iter.sv
// Directed bench for core_mul_iter (STEP_BITS=2): result values, valid timing, busy-start and reset drop.
// Expected latencies follow CORE_MUL_EARLY_TERM_EN when it is defined for the build.

module tb_core_mul_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_ready;
  logic        add;
  logic        long_mul;
  logic        signed_mul;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c_lo;
  logic [31:0] c_hi;
  logic        valid;
  logic [31:0] q_lo;
  logic [31:0] q_hi;
  logic        n;
  logic        z;

  int n_checks = 0;
  int n_fails  = 0;

  core_mul_iter #(.STEP_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_ready   (in_ready),
    .add        (add),
    .long_mul   (long_mul),
    .signed_mul (signed_mul),
    .a          (a),
    .b          (b),
    .c_lo       (c_lo),
    .c_hi       (c_hi),
    .valid      (valid),
    .q_lo       (q_lo),
    .q_hi       (q_hi),
    .n          (n),
    .z          (z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle in which valid is expected, given the multiplier magnitude.
  function automatic int exp_latency(input logic [31:0] bm);
`ifdef CORE_MUL_EARLY_TERM_EN
    logic [31:0] t;
    int d;
    t = bm;
    d = 0;
    while (t != 32'd0) begin
      t = t >> 2;
      d++;
    end
    return d + 2;
`else
    return 18;
`endif
  endfunction

  task automatic scramble_inputs();
    a          = $urandom;
    b          = $urandom;
    c_lo       = $urandom;
    c_hi       = $urandom;
    add        = 1'($urandom_range(0, 1));
    long_mul   = 1'($urandom_range(0, 1));
    signed_mul = 1'($urandom_range(0, 1));
  endtask

  // Drive one operation in cycle 0, then observe cycles 1..24.
  // exp_lat == 0 means no valid is expected (operation dropped by reset).
  task automatic do_op(input string tag,
                       input logic add_i, input logic long_i, input logic sgn_i,
                       input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic [31:0] clo_i, input logic [31:0] chi_i,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input logic exp_n, input logic exp_z,
                       input int exp_lat, input int poke_cycle, input int rst_cycle);
    int vcount;
    int first;
    vcount = 0;
    first  = -1;
    @(negedge clk);
    check_eq({tag, " in_ready_c0"}, 64'(in_ready), 64'd1);
    start      = 1'b1;
    add        = add_i;
    long_mul   = long_i;
    signed_mul = sgn_i;
    a          = a_i;
    b          = b_i;
    c_lo       = clo_i;
    c_hi       = chi_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (valid) begin
        vcount++;
        if (vcount == 1) begin
          first = c;
          check_eq({tag, " q_lo"}, 64'(q_lo), 64'(exp_lo));
          check_eq({tag, " q_hi"}, 64'(q_hi), 64'(exp_hi));
          check_eq({tag, " n"}, 64'(n), 64'(exp_n));
          check_eq({tag, " z"}, 64'(z), 64'(exp_z));
          check_eq({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
        end
      end
      if (rst_cycle > 0 && c == rst_cycle + 1) begin
        check_eq({tag, " in_ready_after_rst"}, 64'(in_ready), 64'd1);
        check_eq({tag, " q_lo_after_rst"}, 64'(q_lo), 64'd0);
        check_eq({tag, " q_hi_after_rst"}, 64'(q_hi), 64'd0);
        check_eq({tag, " nz_after_rst"}, 64'({n, z}), 64'd0);
      end
      if (c == poke_cycle) begin
        start = 1'b1;
        scramble_inputs();
      end
      if (c == rst_cycle) begin
        rst = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
    end
    if (exp_lat > 0) begin
      check_eq({tag, " valid_count"}, 64'(vcount), 64'd1);
      check_eq({tag, " valid_cycle"}, 64'(first), 64'(exp_lat));
      @(negedge clk);
      check_eq({tag, " hold_lo"}, 64'(q_lo), 64'(exp_lo));
      check_eq({tag, " hold_hi"}, 64'(q_hi), 64'(exp_hi));
    end else begin
      check_eq({tag, " valid_count"}, 64'(vcount), 64'd0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset valid", 64'(valid), 64'd0);
    check_eq("reset q_lo", 64'(q_lo), 64'd0);
    check_eq("reset q_hi", 64'(q_hi), 64'd0);
    check_eq("reset n", 64'(n), 64'd0);
    check_eq("reset z", 64'(z), 64'd0);

    //     tag          add   long  sgn   a              b              c_lo           c_hi           exp_lo         exp_hi         n     z     lat                          poke rst
    do_op("mul_7x6",   1'b0, 1'b0, 1'b0, 32'd7,         32'd6,         32'd0,         32'd0,         32'd42,        32'd0,         1'b0, 1'b0, exp_latency(32'd6),          0,   0);
    do_op("umull_max", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd0,         32'h00000001,  32'hFFFFFFFE,  1'b1, 1'b0, exp_latency(32'hFFFFFFFF),   0,   0);
    do_op("smull_m2x3",1'b0, 1'b1, 1'b1, 32'hFFFFFFFE,  32'd3,         32'd0,         32'd0,         32'hFFFFFFFA,  32'hFFFFFFFF,  1'b1, 1'b0, exp_latency(32'd3),          0,   0);
    do_op("smull_min", 1'b0, 1'b1, 1'b1, 32'h80000000,  32'h80000000,  32'd0,         32'd0,         32'h00000000,  32'h40000000,  1'b0, 1'b0, exp_latency(32'h80000000),   0,   0);
    do_op("smull_5xm3",1'b0, 1'b1, 1'b1, 32'd5,         32'hFFFFFFFD,  32'd0,         32'd0,         32'hFFFFFFF1,  32'hFFFFFFFF,  1'b1, 1'b0, exp_latency(32'd3),          0,   0);
    do_op("umlal_cy",  1'b1, 1'b1, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd1,         32'd0,         32'h00000000,  32'h00000001,  1'b0, 1'b0, exp_latency(32'd1),          0,   0);
    do_op("smlal_wrap",1'b1, 1'b1, 1'b1, 32'hFFFFFFFF,  32'd1,         32'd1,         32'd0,         32'h00000000,  32'h00000000,  1'b0, 1'b1, exp_latency(32'd1),          0,   0);
    do_op("mla_zero",  1'b1, 1'b0, 1'b0, 32'd0,         32'd9,         32'd0,         32'd0,         32'h00000000,  32'h00000000,  1'b0, 1'b1, exp_latency(32'd9),          0,   0);
    do_op("mla_trunc", 1'b1, 1'b0, 1'b1, 32'h00010000,  32'h00010000,  32'd5,         32'h12345678,  32'h00000005,  32'h00000000,  1'b0, 1'b0, exp_latency(32'h00010000),   0,   0);
    do_op("busy_start",1'b0, 1'b0, 1'b0, 32'd3,         32'h80000000,  32'd0,         32'd0,         32'h80000000,  32'h00000000,  1'b1, 1'b0, exp_latency(32'h80000000),   5,   0);
    do_op("rst_drop",  1'b0, 1'b0, 1'b0, 32'd3,         32'h80000000,  32'd0,         32'd0,         32'h00000000,  32'h00000000,  1'b0, 1'b0, 0,                           0,   8);
    do_op("mul_5x1",   1'b0, 1'b0, 1'b0, 32'd5,         32'd1,         32'd0,         32'd0,         32'd5,         32'd0,         1'b0, 1'b0, exp_latency(32'd1),          0,   0);
    do_op("mul_5x0",   1'b0, 1'b0, 1'b0, 32'd5,         32'd0,         32'd0,         32'd0,         32'd0,         32'd0,         1'b0, 1'b1, exp_latency(32'd0),          0,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
